// File: rtl/cva6_mem_model_pkg.sv
// -----------------------------------------------------------------------------
// cva6_mem_model_pkg
// Shared types and constants for the CVA6 LSU memory-side responder model.
//   load_state_e      : load responder FSM states
//   DEFAULT_*         : default latencies and store queue depth
//   LAT_W             : width of the latency counters
//   lat_minus()       : saturating "latency minus offset" reload value helper
// -----------------------------------------------------------------------------
package cva6_mem_model_pkg;

   typedef enum logic [1:0] {
      L_IDLE  = 2'd0,
      L_WAIT  = 2'd1,
      L_RESP  = 2'd2,
      L_REARM = 2'd3
   } load_state_e;

   localparam int unsigned DEFAULT_LOAD_LAT    = 32'd3;
   localparam int unsigned DEFAULT_STORE_LAT   = 32'd2;
   localparam int unsigned DEFAULT_STORE_DEPTH = 32'd4;

   // Latencies are limited to 1..255, so 8 bits hold any reload value.
   localparam int unsigned LAT_W = 32'd8;
   localparam logic [LAT_W-1:0] LAT_ZERO = 8'd0;
   localparam logic [LAT_W-1:0] LAT_ONE  = 8'd1;

   // Counter reload value for a latency; saturates at zero so an unused
   // reload (e.g. LOAD_LAT = 1) still elaborates to a legal constant.
   function automatic logic [LAT_W-1:0] lat_minus(input int unsigned lat,
                                                 input int unsigned sub);
      int unsigned diff;
      diff = (lat > sub) ? (lat - sub) : 32'd0;
      return diff[LAT_W-1:0];
   endfunction

endpackage

// File: rtl/cva6_mem_store_fifo.sv
// -----------------------------------------------------------------------------
// cva6_mem_store_fifo
// Count-based pending-store queue. Entries carry no payload: only their
// number and order matter, so the queue is tracked by pointers and a count.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : add one entry (dropped if full and not popping)
//   pop_i         : remove the head entry
//   full_o        : count == STORE_DEPTH
//   empty_o       : count == 0
//   count_o       : occupied entries, 0..STORE_DEPTH
//   overflow_o    : sticky, set when a push is dropped; cleared by reset only
// -----------------------------------------------------------------------------
module cva6_mem_store_fifo
   import cva6_mem_model_pkg::*;
#(
   parameter int unsigned STORE_DEPTH = DEFAULT_STORE_DEPTH
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         push_i,
   input  logic                         pop_i,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(STORE_DEPTH):0] count_o,
   output logic                         overflow_o
);

   localparam int unsigned CNT_W = $clog2(STORE_DEPTH) + 32'd1;
   localparam int unsigned PTR_W = $clog2(STORE_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STORE_DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(32'd1);

   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             overflow_q, overflow_d;

   logic full_s;
   logic pop_s;
   logic push_acc_s;
   logic drop_s;

   // Push/pop qualification: a pop frees the slot a same-cycle push needs.
   always_comb begin
      full_s     = (count_q == CNT_FULL);
      pop_s      = pop_i && (count_q != CNT_ZERO);
      push_acc_s = push_i && (!full_s || pop_s);
      drop_s     = push_i && full_s && !pop_s;
   end

   // Next-state for count, pointers (wrap naturally, depth is a power of 2) and sticky overflow.
   always_comb begin
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow_q | drop_s;
      case ({push_acc_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      if (push_acc_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   // State registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q    <= CNT_ZERO;
         wr_ptr_q   <= {PTR_W{1'b0}};
         rd_ptr_q   <= {PTR_W{1'b0}};
         overflow_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
      end
   end

   // Status outputs decoded from flops only.
   always_comb begin
      full_o     = full_s;
      empty_o    = (count_q == CNT_ZERO);
      count_o    = count_q;
      overflow_o = overflow_q;
   end

endmodule

// File: rtl/cva6_mem_resp_model.sv
// -----------------------------------------------------------------------------
// cva6_mem_resp_model
// Memory-side responder for the CVA6 LSU model. Loads are answered LOAD_LAT
// cycles after acceptance; stores drain in order, each spending STORE_LAT
// cycles at the queue head. One shared memory port: a load response always
// wins the cycle and a ready store waits one cycle for it.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   load_req_i        : load request level, held until the response is seen
//   store_req_i       : one-cycle pulse per store to drain
//   load_mem_resp_o   : one-cycle load completion pulse
//   store_mem_resp_o  : one-cycle store completion pulse, queue order
//   load_busy_o       : load FSM not idle
//   store_pending_o   : occupied store entries
//   store_overflow_o  : sticky, a store was dropped on a full queue
// -----------------------------------------------------------------------------
module cva6_mem_resp_model
   import cva6_mem_model_pkg::*;
#(
   parameter int unsigned LOAD_LAT    = DEFAULT_LOAD_LAT,
   parameter int unsigned STORE_LAT   = DEFAULT_STORE_LAT,
   parameter int unsigned STORE_DEPTH = DEFAULT_STORE_DEPTH
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         load_req_i,
   input  logic                         store_req_i,
   output logic                         load_mem_resp_o,
   output logic                         store_mem_resp_o,
   output logic                         load_busy_o,
   output logic [$clog2(STORE_DEPTH):0] store_pending_o,
   output logic                         store_overflow_o
);

   localparam int unsigned CNT_W = $clog2(STORE_DEPTH) + 32'd1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);

   // WAIT covers LOAD_LAT-1 cycles (lcnt counts down to zero inclusive),
   // then RESP is the LOAD_LAT-th cycle after acceptance.
   localparam logic [LAT_W-1:0] LOAD_RELOAD  = lat_minus(LOAD_LAT, 32'd2);
   localparam logic [LAT_W-1:0] STORE_RELOAD = lat_minus(STORE_LAT, 32'd1);
   localparam logic             LOAD_DIRECT  = (LOAD_LAT == 32'd1);

   load_state_e      state_q, state_d;
   logic [LAT_W-1:0] lcnt_q, lcnt_d;
   logic [LAT_W-1:0] stimer_q, stimer_d;

   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic [CNT_W-1:0] fifo_count_s;
   logic             fifo_overflow_s;
   logic             store_pop_s;
   logic             store_remain_s;

   cva6_mem_store_fifo #(
      .STORE_DEPTH (STORE_DEPTH)
   ) u_store_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .push_i     (store_req_i),
      .pop_i      (store_pop_s),
      .full_o     (fifo_full_s),
      .empty_o    (fifo_empty_s),
      .count_o    (fifo_count_s),
      .overflow_o (fifo_overflow_s)
   );

   // Port arbitration: the head store responds only when its timer expired and no load owns the port.
   always_comb begin
      store_pop_s = !fifo_empty_s && (stimer_q == LAT_ZERO) && (state_q != L_RESP);
      // Entries left after this cycle's pop, counting a same-cycle accepted push.
      store_remain_s = (fifo_count_s > CNT_ONE) ||
                       (store_req_i && (!fifo_full_s || store_pop_s));
   end

   // Head timer: reload for a new head, count down, hold at zero while blocked by a load.
   always_comb begin
      stimer_d = stimer_q;
      if (store_pop_s) begin
         if (store_remain_s) begin
            stimer_d = STORE_RELOAD;
         end else begin
            stimer_d = LAT_ZERO;
         end
      end else if (fifo_empty_s) begin
         if (store_req_i) begin
            stimer_d = STORE_RELOAD;
         end else begin
            stimer_d = LAT_ZERO;
         end
      end else if (stimer_q != LAT_ZERO) begin
         stimer_d = stimer_q - LAT_ONE;
      end else begin
         stimer_d = stimer_q;
      end
   end

   // Load FSM next-state and latency counter.
   always_comb begin
      state_d = state_q;
      lcnt_d  = lcnt_q;
      case (state_q)
         L_IDLE: begin
            if (load_req_i) begin
               if (LOAD_DIRECT) begin
                  state_d = L_RESP;
               end else begin
                  state_d = L_WAIT;
                  lcnt_d  = LOAD_RELOAD;
               end
            end else begin
               state_d = L_IDLE;
            end
         end
         // An accepted load completes even if the request drops meanwhile.
         L_WAIT: begin
            if (lcnt_q == LAT_ZERO) begin
               state_d = L_RESP;
            end else begin
               lcnt_d = lcnt_q - LAT_ONE;
            end
         end
         L_RESP: begin
            state_d = L_REARM;
         end
         // Wait for the requester to drop its level so one request gets one response.
         L_REARM: begin
            if (!load_req_i) begin
               state_d = L_IDLE;
            end else begin
               state_d = L_REARM;
            end
         end
         default: begin
            state_d = L_IDLE;
            lcnt_d  = LAT_ZERO;
         end
      endcase
   end

   // State registers for load FSM, load counter and head timer.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= L_IDLE;
         lcnt_q   <= LAT_ZERO;
         stimer_q <= LAT_ZERO;
      end else begin
         state_q  <= state_d;
         lcnt_q   <= lcnt_d;
         stimer_q <= stimer_d;
      end
   end

   // Outputs, decoded from flops only.
   always_comb begin
      load_mem_resp_o  = (state_q == L_RESP);
      load_busy_o      = (state_q != L_IDLE);
      store_mem_resp_o = store_pop_s;
      store_pending_o  = fifo_count_s;
      store_overflow_o = fifo_overflow_s;
   end

endmodule

// File: doc/cva6_mem_resp_model.md
# cva6_mem_resp_model

Memory-side responder model for the CVA6 LSU verification environment. It accepts load requests (a level-held request line) and store drain requests (single-cycle pulses) from the LSU model. It returns single-cycle `load_mem_resp_o` and `store_mem_resp_o` pulses after configurable latencies. A single memory port is modelled, so at most one response is issued per cycle, and loads have priority.

## Interface
- `LOAD_LAT`, default 3: cycles from load acceptance to load response; legal range 1..255.
- `STORE_LAT`, default 2: cycles a store spends at the FIFO head before it may respond; legal range 1..255.
- `STORE_DEPTH`, default 4: number of pending-store entries; must be a power of 2, at least 2.
- `clk_i`, input, 1: clock.
- `rst_ni`, input, 1: reset, asynchronous, active-low.
- `load_req_i`, input, 1: load request level; held high by the requester until it sees the response.
- `store_req_i`, input, 1: one-cycle pulse per committed store to drain.
- `load_mem_resp_o`, output, 1: one-cycle load completion pulse.
- `store_mem_resp_o`, output, 1: one-cycle store completion pulse, in FIFO order.
- `load_busy_o`, output, 1: high while the load FSM is not in `L_IDLE`.
- `store_pending_o`, output, $clog2(STORE_DEPTH)+1: number of occupied store entries.
- `store_overflow_o`, output, 1: sticky flag, set when a store is dropped because the FIFO is full.

## Operation
- Reset values: all outputs 0. Load FSM is in `L_IDLE`. FIFO is empty, pointers are 0, head timer is 0.
- Load FSM states: `L_IDLE`, `L_WAIT`, `L_RESP`, `L_REARM`.
  - `L_IDLE`, with `load_req_i` = 1: go to `L_RESP` if `LOAD_LAT` = 1. Otherwise go to `L_WAIT` with `lcnt` = `LOAD_LAT` - 2.
  - `L_WAIT`: if `lcnt` = 0, go to `L_RESP`; else decrement `lcnt`.
  - `L_RESP`: `load_mem_resp_o` = 1 for exactly this cycle, then go to `L_REARM`.
  - `L_REARM`: stay until `load_req_i` is sampled 0, then go to `L_IDLE`. This absorbs the requester's deassertion lag and guarantees one response per request.
- An accepted load always completes. Dropping `load_req_i` during `L_WAIT` does not cancel it.
- Store FIFO:
  - `store_req_i` pushes one entry.
  - A push into an empty FIFO loads the head timer with `STORE_LAT` - 1.
  - When `count` > 0 and the timer is nonzero, the timer decrements each cycle.
- Store response rule: `store_mem_resp_o` = (`count` != 0) && (timer = 0) && (FSM != `L_RESP`). The output is decoded only from flops.
  - A response pops the head.
  - If entries remain after the pop, the timer reloads `STORE_LAT` - 1 for the new head.
- Load priority: a store whose timer has reached 0 waits at 0, holding, while the FSM is in `L_RESP`. It then responds on the next free cycle.
- Full FIFO:
  - Push with no pop in the same cycle: the entry is dropped, `store_overflow_o` is set, and `count` is unchanged.
  - Push and pop in the same cycle: accepted, and `count` is unchanged.
- Pointers wrap modulo `STORE_DEPTH`. `count` ranges 0..`STORE_DEPTH`.
- Asserting `rst_ni` low at any point, including mid-wait or mid-FIFO, returns everything to reset values immediately. `store_overflow_o` is cleared only by reset.

## Timing
- Load: `load_req_i` sampled high in `L_IDLE` at edge t → `load_mem_resp_o` high in cycle t+`LOAD_LAT`.
- Earliest next acceptance is the first edge after `load_req_i` is sampled low in `L_REARM`.
- Store into an empty FIFO: pulse at edge t → `store_mem_resp_o` in cycle t+`STORE_LAT`, absent a load conflict.
- Back-to-back stores: consecutive responses are `STORE_LAT` cycles apart. With `STORE_LAT` = 1 this is one response per cycle.
- A load conflict delays the pending store response by exactly one cycle per `L_RESP` cycle.
- `store_pending_o` updates on the edge after a push or pop.

## Structure
- Package `cva6_mem_model_pkg`:
  - load FSM state enum `load_state_e`;
  - default latency constants.
- Sub-module `cva6_mem_store_fifo`:
  - count-based FIFO, parameterised by `STORE_DEPTH`;
  - ports: push, pop, full, empty, count, overflow.
- The head timer, arbitration and load FSM live in the top module.

## Test plan
- Reset, then a single load with `LOAD_LAT`=3: `load_req_i` high from cycle 2 to cycle 7. Required: one `load_mem_resp_o` pulse in cycle 5 only. `load_busy_o` high in cycles 3–8.
- A single store with `STORE_LAT`=2, pulse in cycle 4: `store_mem_resp_o` in cycle 6. `store_pending_o` reads 1 in cycles 5–6 and 0 in cycle 7.
- Four store pulses in cycles 1–4 with `STORE_LAT`=2: responses in cycles 3, 5, 7, 9. `store_overflow_o` stays 0.
- Five store pulses in cycles 1–5 with `STORE_LAT`=8: the fifth store is dropped, `store_overflow_o` goes to 1 in cycle 6, and exactly 4 store responses follow.
- Conflict: a store becomes eligible in the same cycle as `L_RESP`. The load response is issued that cycle and the store response one cycle later.
- Reset asserted during `L_WAIT` with 2 stores pending: all outputs go to 0 immediately, and no responses follow after reset release.
